// File: rtl/serial_pkg.sv
// serial_pkg
//  Shared definitions for the serial link: FSM state encodings, line levels
//  for the framing bits, and the bit-counter width helper used by both the
//  serializer and the deserializer.
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PAR  = 2'd2,
    ST_STOP = 2'd3
  } state_t;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  // Bits needed to count 0 .. width-1, never less than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_hold_reg.sv
// serial_hold_reg
//  One-entry output register with a valid/ready handshake. A word offered on
//  load is captured when the register is empty or being drained the same
//  edge; otherwise the held word is kept and ovr_err pulses for one cycle.
// Ports
//  clk        in   rising-edge clock
//  clr        in   asynchronous active-low reset
//  load       in   a good word is offered this cycle
//  din        in   word offered with load
//  out_ready  in   consumer accepts the held word
//  out_data   out  held word
//  out_valid  out  register holds a word
//  ovr_err    out  1-cycle pulse: offered word dropped because register full
module serial_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             ovr_err
);

  logic can_load;
  assign can_load = !out_valid || out_ready;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      ovr_err   <= 1'b0;
    end else begin
      ovr_err <= 1'b0;
      if (load && can_load) begin
        // Covers the simultaneous accept+load case: valid stays high.
        out_data  <= din;
        out_valid <= 1'b1;
      end else begin
        if (load) ovr_err <= 1'b1;
        if (out_valid && out_ready) out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_deser.sv
// serial_deser
//  Samples a 1-bit serial line every clock, recognises framed words
//  (start=1, WIDTH data bits LSB-first, optional even parity, stop=0),
//  and hands the assembled word to a one-entry valid/ready output register.
//  Framing and parity errors pulse for one cycle and discard the word.
// Configuration
//  SERIAL_PARITY_EN  defined: an even-parity bit follows the data bits.
//                    undefined: no parity bit, par_err is tied to 0.
// Ports
//  clk        in   rising-edge clock, sin sampled every posedge
//  clr        in   asynchronous active-low reset
//  sin        in   serial input, idle level 0
//  out_data   out  assembled word, stable while out_valid=1
//  out_valid  out  word held in output register
//  out_ready  in   consumer accepts (transfer on out_valid & out_ready)
//  busy       out  receiver is inside a frame
//  par_err    out  1-cycle pulse: parity mismatch
//  frm_err    out  1-cycle pulse: stop bit sampled as 1
//  ovr_err    out  1-cycle pulse: good word dropped, output register full
module serial_deser
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sin,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             par_err,
  output logic             frm_err,
  output logic             ovr_err
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  sr;
  logic              last_bit;
  logic              stop_smp;
  logic              frm_bad;
  logic              par_fail;
  logic              good;

  assign last_bit = (cnt == CNT_LAST);
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (sin == START_BIT) state_nxt = ST_DATA;
      ST_DATA: if (last_bit) begin
`ifdef SERIAL_PARITY_EN
        state_nxt = ST_PAR;
`else
        state_nxt = ST_STOP;
`endif
      end
`ifdef SERIAL_PARITY_EN
      ST_PAR:  state_nxt = ST_STOP;
`endif
      ST_STOP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Data bits enter at the MSB and move right, so after WIDTH shifts the
  // first (LSB) bit sits in sr[0].
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt <= '0;
      sr  <= '0;
    end else if (state == ST_IDLE) begin
      cnt <= '0;
    end else if (state == ST_DATA) begin
      sr  <= {sin, sr[WIDTH-1:1]};
      cnt <= cnt + 1'b1;
    end
  end

  assign stop_smp = (state == ST_STOP);
  assign frm_bad  = stop_smp && (sin != STOP_BIT);

`ifdef SERIAL_PARITY_EN
  logic par_bad;
  logic par_err_q;

  // Even parity: the parity bit equals the XOR of the data bits.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      par_bad <= 1'b0;
    end else if (state == ST_IDLE) begin
      par_bad <= 1'b0;
    end else if (state == ST_PAR) begin
      par_bad <= sin ^ (^sr);
    end
  end

  // A framing error outranks a parity error on the same frame.
  assign par_fail = stop_smp && !frm_bad && par_bad;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) par_err_q <= 1'b0;
    else      par_err_q <= par_fail;
  end
  assign par_err = par_err_q;
`else
  assign par_fail = 1'b0;
  assign par_err  = 1'b0;
`endif

  assign good = stop_smp && !frm_bad && !par_fail;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) frm_err <= 1'b0;
    else      frm_err <= frm_bad;
  end

  serial_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk       (clk),
    .clr       (clr),
    .load      (good),
    .din       (sr),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .ovr_err   (ovr_err)
  );

endmodule
